sni_host: RTL and testbench

- Initiator end of the Super Nintendo Interface (SNI) UART protocol.
- Accepts one command at a time from local logic: PING, READ, WRITE, WAITNMI or VERSION.
- Serializes the command packet onto a byte-wide TX stream, then parses the responder's reply from a byte-wide RX stream.
- Sits between a UART byte engine and an on-FPGA debug/test master, so the FPGA can drive a remote SNI target.

---
 rtl/sni_host.sv | 245 ++++++++++++++++++++++++
 tb/tb_sni_host.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sni_host.sv
// rtl/sni_host.sv - Super Nintendo Interface (SNI) UART protocol initiator
//
// Takes one command at a time (PING, READ, WRITE, WAITNMI, VERSION), sends the
// packet header on a byte-wide TX stream, then parses the responder's reply
// from a byte-wide RX stream. WRITE payload bytes pass straight from wr_* to tx_*.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/addr/len/ping       command fields, latched on accept
//   wr_data/wr_valid/wr_ready  WRITE payload stream
//   rd_data/rd_valid           READ payload / PING echo strobes
//   done/resp_err              completion pulse and its error flag
//   tx_data/tx_valid/tx_ready  byte stream to the UART
//   rx_data/rx_valid           byte strobes from the UART
//
// Optional: define SNI_HOST_TIMEOUT_EN to add a response watchdog that ends the
// command with resp_err after TIMEOUT_CYCLES without a received byte.

module sni_host #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter logic [7:0]  PROTO_VERSION  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  cmd_ping,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        resp_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam logic [2:0] OP_PING    = 3'd0;
  localparam logic [2:0] OP_READ    = 3'd1;
  localparam logic [2:0] OP_WRITE   = 3'd2;
  localparam logic [2:0] OP_WAITNMI = 3'd3;
  localparam logic [2:0] OP_VERSION = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    WAIT_LEN,
    RECV,
    SEND_DATA,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [23:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  ping_q;
  logic [2:0]  idx;
  logic [8:0]  rem;
  logic        err_q;

`ifdef SNI_HOST_TIMEOUT_EN
  logic [23:0] wd;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic [2:0] hdr_last;
  logic [7:0] hdr_byte;
  logic [7:0] exp_len;

  // Index of the final header byte for the latched op.
  always_comb begin
    hdr_last = 3'd0;
    case (op_q)
      OP_PING:           hdr_last = 3'd1;
      OP_READ, OP_WRITE: hdr_last = 3'd4;
      default:           hdr_last = 3'd0;
    endcase
  end

  // Header byte at the current index; address goes out little-endian.
  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      3'd0:    hdr_byte = {5'd0, op_q};
      3'd1:    hdr_byte = (op_q == OP_PING) ? ping_q : addr_q[7:0];
      3'd2:    hdr_byte = addr_q[15:8];
      3'd3:    hdr_byte = addr_q[23:16];
      default: hdr_byte = len_q;
    endcase
  end

  // Response length the responder must announce for each op.
  always_comb begin
    exp_len = 8'h00;
    case (op_q)
      OP_PING, OP_VERSION: exp_len = 8'h01;
      OP_READ:             exp_len = len_q;
      default:             exp_len = 8'h00;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign resp_err  = (state == DONE) && err_q;
  assign wr_ready  = (state == SEND_DATA) && (rem != 9'd0) && tx_ready;
  assign tx_valid  = (state == SEND_HDR) ||
                     ((state == SEND_DATA) && (rem != 9'd0) && wr_valid);
  assign tx_data   = (state == SEND_DATA) ? wr_data :
                     (state == SEND_HDR)  ? hdr_byte : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 3'd0;
      addr_q   <= 24'd0;
      len_q    <= 8'd0;
      ping_q   <= 8'd0;
      idx      <= 3'd0;
      rem      <= 9'd0;
      err_q    <= 1'b0;
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
`ifdef SNI_HOST_TIMEOUT_EN
      wd       <= 24'd0;
`endif
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            ping_q <= cmd_ping;
            idx    <= 3'd0;
            rem    <= 9'd0;
            if (cmd_op > OP_VERSION) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= SEND_HDR;
            end
          end
        end

        SEND_HDR: begin
          if (tx_ready) begin
            if (idx == hdr_last) begin
              state <= WAIT_LEN;
`ifdef SNI_HOST_TIMEOUT_EN
              wd    <= 24'd0;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        WAIT_LEN: begin
          if (rx_valid) begin
            if (rx_data != exp_len) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              case (op_q)
                OP_PING, OP_VERSION: state <= RECV;
                OP_READ: begin
                  rem   <= {1'b0, len_q};
                  state <= (len_q == 8'd0) ? DONE : RECV;
                end
                OP_WRITE: begin
                  rem   <= {1'b0, len_q};
                  state <= (len_q == 8'd0) ? DONE : SEND_DATA;
                end
                default: state <= DONE;
              endcase
            end
          end
        end

        RECV: begin
          if (rx_valid) begin
            case (op_q)
              OP_READ: begin
                rd_valid <= 1'b1;
                rd_data  <= rx_data;
                rem      <= rem - 9'd1;
                if (rem == 9'd1) state <= DONE;
              end
              OP_PING: begin
                rd_valid <= 1'b1;
                rd_data  <= rx_data;
                err_q    <= (rx_data != ping_q);
                state    <= DONE;
              end
              default: begin
                err_q <= (rx_data != PROTO_VERSION);
                state <= DONE;
              end
            endcase
          end
        end

        SEND_DATA: begin
          // RX bytes here are unsolicited and dropped.
          if (wr_valid && tx_ready && (rem != 9'd0)) begin
            rem <= rem - 9'd1;
            if (rem == 9'd1) state <= DONE;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase

`ifdef SNI_HOST_TIMEOUT_EN
      // Any received byte restarts the watchdog; expiry overrides the case above.
      if ((state == WAIT_LEN) || (state == RECV)) begin
        if (rx_valid) begin
          wd <= 24'd0;
        end else if (wd == TIMEOUT_CYCLES - 24'd1) begin
          err_q <= 1'b1;
          state <= DONE;
        end else begin
          wd <= wd + 24'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sni_host.sv
// tb/tb_sni_host.sv - directed table-driven bench for sni_host
module tb_sni_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  cmd_ping;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done;
  logic        resp_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  always #5 clk = ~clk;

  sni_host dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ping(cmd_ping),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .resp_err(resp_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  int         hs_cnt   = 0;
  int         done_cnt = 0;
  logic       last_err = 1'b0;

  // Observer: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (rd_valid) rd_q.push_back(rd_data);
      if (wr_valid && wr_ready) hs_cnt <= hs_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        last_err <= resp_err;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Byte i of tx/rx/rd/wr lives at [8*i +: 8].
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [7:0]  ping;
    int          hdr_n;
    int          tx_n;
    logic [63:0] tx;
    int          rx_n;
    logic [31:0] rx;
    int          rd_n;
    logic [31:0] rd;
    int          wr_n;
    logic [15:0] wr;
    int          hs_n;
    logic        err;
    logic        tog;
  } vec_t;

  vec_t vecs[15];

  task automatic start_cmd(input logic [2:0] op, input logic [23:0] addr,
                           input logic [7:0] len, input logic [7:0] ping);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_ping  = ping;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int tx0, rd0, dn0, hs0, rx_i, tail, k, ntx, nrd;
    tx0 = tx_q.size(); rd0 = rd_q.size(); dn0 = done_cnt; hs0 = hs_cnt;
    start_cmd(v.op, v.addr, v.len, v.ping);
    rx_i = 0; tail = 0;
    for (int cyc = 0; cyc < 200 && tail < 3; cyc++) begin
      rx_valid = 1'b0;
      if ((tx_q.size() - tx0) >= v.hdr_n && rx_i < v.rx_n) begin
        rx_valid = 1'b1;
        rx_data  = v.rx[8*rx_i +: 8];
        rx_i++;
      end
      tx_ready = v.tog ? ((cyc % 2) == 0) : 1'b1;
      k = hs_cnt - hs0;
      wr_valid = (k < v.wr_n);
      if (k < 2) wr_data = v.wr[8*k +: 8];
      @(posedge clk); #1;
      if (done_cnt > dn0 && rx_i >= v.rx_n) tail++;
    end
    rx_valid = 1'b0; wr_valid = 1'b0; tx_ready = 1'b1;
    ntx = tx_q.size() - tx0;
    nrd = rd_q.size() - rd0;
    chk({v.name, " done_count"}, done_cnt - dn0, 1);
    chk({v.name, " resp_err"}, last_err, v.err);
    chk({v.name, " tx_count"}, ntx, v.tx_n);
    for (int i = 0; i < v.tx_n && i < ntx; i++)
      chk($sformatf("%s tx[%0d]", v.name, i), tx_q[tx0+i], v.tx[8*i +: 8]);
    chk({v.name, " rd_count"}, nrd, v.rd_n);
    for (int i = 0; i < v.rd_n && i < nrd; i++)
      chk($sformatf("%s rd[%0d]", v.name, i), rd_q[rd0+i], v.rd[8*i +: 8]);
    chk({v.name, " wr_handshakes"}, hs_cnt - hs0, v.hs_n);
  endtask

  task automatic wait_tx(input int base, input int n, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if ((tx_q.size() - base) >= n) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int   dn0, tx0;
    logic ok;

    //           name        op    addr         len    ping   hdr tx  tx bytes                rx  rx bytes       rd  rd bytes       wr  wr        hs err   tog
    vecs[0]  = '{"ping_a5",  3'd0, 24'h000000, 8'h00, 8'hA5, 2, 2, 64'h000000000000A500, 2, 32'h0000A501, 1, 32'h000000A5, 0, 16'h0000, 0, 1'b0, 1'b0};
    vecs[1]  = '{"read3",    3'd1, 24'hF50010, 8'h03, 8'h00, 5, 5, 64'h00000003F5001001, 4, 32'h33221103, 3, 32'h00332211, 0, 16'h0000, 0, 1'b0, 1'b0};
    vecs[2]  = '{"write2",   3'd2, 24'hE00000, 8'h02, 8'h00, 5, 7, 64'h00C35A02E0000002, 1, 32'h00000000, 0, 32'h00000000, 2, 16'hC35A, 2, 1'b0, 1'b1};
    vecs[3]  = '{"read_badl",3'd1, 24'h000000, 8'h04, 8'h00, 5, 5, 64'h0000000400000001, 3, 32'h00BBAA02, 0, 32'h00000000, 0, 16'h0000, 0, 1'b1, 1'b0};
    vecs[4]  = '{"ping_3c",  3'd0, 24'h000000, 8'h00, 8'h3C, 2, 2, 64'h0000000000003C00, 2, 32'h00003C01, 1, 32'h0000003C, 0, 16'h0000, 0, 1'b0, 1'b0};
    vecs[5]  = '{"ping_bad", 3'd0, 24'h000000, 8'h00, 8'h77, 2, 2, 64'h0000000000007700, 2, 32'h00007801, 1, 32'h00000078, 0, 16'h0000, 0, 1'b1, 1'b0};
    vecs[6]  = '{"version",  3'd4, 24'h000000, 8'h00, 8'h00, 1, 1, 64'h0000000000000004, 2, 32'h00000001, 0, 32'h00000000, 0, 16'h0000, 0, 1'b0, 1'b0};
    vecs[7]  = '{"ver_bad",  3'd4, 24'h000000, 8'h00, 8'h00, 1, 1, 64'h0000000000000004, 2, 32'h00000501, 0, 32'h00000000, 0, 16'h0000, 0, 1'b1, 1'b0};
    vecs[8]  = '{"waitnmi",  3'd3, 24'h000000, 8'h00, 8'h00, 1, 1, 64'h0000000000000003, 1, 32'h00000000, 0, 32'h00000000, 0, 16'h0000, 0, 1'b0, 1'b0};
    vecs[9]  = '{"read0",    3'd1, 24'h123456, 8'h00, 8'h00, 5, 5, 64'h0000000012345601, 1, 32'h00000000, 0, 32'h00000000, 0, 16'h0000, 0, 1'b0, 1'b0};
    vecs[10] = '{"write0",   3'd2, 24'hABCDEF, 8'h00, 8'h00, 5, 5, 64'h00000000ABCDEF02, 1, 32'h00000000, 0, 32'h00000000, 0, 16'h0000, 0, 1'b0, 1'b1};
    vecs[11] = '{"op6",      3'd6, 24'h000000, 8'h00, 8'h00, 0, 0, 64'h0000000000000000, 0, 32'h00000000, 0, 32'h00000000, 0, 16'h0000, 0, 1'b1, 1'b0};
    vecs[12] = '{"op5",      3'd5, 24'h000000, 8'h00, 8'h00, 0, 0, 64'h0000000000000000, 0, 32'h00000000, 0, 32'h00000000, 0, 16'h0000, 0, 1'b1, 1'b0};
    vecs[13] = '{"write_badl",3'd2,24'h000010, 8'h02, 8'h00, 5, 5, 64'h0000000200001002, 1, 32'h00000001, 0, 32'h00000000, 2, 16'hC35A, 0, 1'b1, 1'b0};
    vecs[14] = '{"read1_tog",3'd1, 24'h0000FF, 8'h01, 8'h00, 5, 5, 64'h000000010000FF01, 2, 32'h00009E01, 1, 32'h0000009E, 0, 16'h0000, 0, 1'b0, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 24'd0; cmd_len = 8'd0;
    cmd_ping = 8'd0; wr_data = 8'd0; wr_valid = 1'b0; tx_ready = 1'b1;
    rx_data = 8'd0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset done", done, 1'b0);
    chk("reset resp_err", resp_err, 1'b0);
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset wr_ready", wr_ready, 1'b0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Invalid op: done and resp_err the very next cycle, nothing transmitted.
    tx0 = tx_q.size();
    start_cmd(3'd6, 24'd0, 8'd0, 8'd0);
    @(negedge clk);
    chk("badop done next cycle", done, 1'b1);
    chk("badop resp_err", resp_err, 1'b1);
    chk("badop tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    chk("badop done one cycle", done, 1'b0);
    chk("badop back to idle", cmd_ready, 1'b1);
    chk("badop no tx", tx_q.size() - tx0, 0);

    // WAITNMI: long silence, then done one cycle after the length byte.
    dn0 = done_cnt; tx0 = tx_q.size();
    start_cmd(3'd3, 24'd0, 8'd0, 8'd0);
    wait_tx(tx0, 1, ok);
    chk("waitnmi hdr sent", ok, 1'b1);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("waitnmi no early done", done_cnt - dn0, 0);
    chk("waitnmi still busy", cmd_ready, 1'b0);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h00;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("waitnmi done after rx", done, 1'b1);
    chk("waitnmi resp_err", resp_err, 1'b0);

    // Reset in the middle of a WRITE payload aborts with no done.
    @(posedge clk); #1;
    tx0 = tx_q.size();
    start_cmd(3'd2, 24'h000000, 8'h03, 8'h00);
    wait_tx(tx0, 5, ok);
    chk("rstwr hdr sent", ok, 1'b1);
    rx_valid = 1'b1; rx_data = 8'h00;
    @(posedge clk); #1;
    rx_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'h11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstwr in payload", tx_valid, 1'b1);
    dn0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("rstwr tx_valid", tx_valid, 1'b0);
    chk("rstwr cmd_ready", cmd_ready, 1'b1);
    chk("rstwr wr_ready", wr_ready, 1'b0);
    chk("rstwr done", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstwr no done pulse", done_cnt - dn0, 0);
    chk("rstwr idle", cmd_ready, 1'b1);

    // Normal command after the abort.
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
